alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Request/response sequencer in front of a fixed-latency ALU.
// Drives the ALU for ALU_LAT cycles, captures its result, and holds it until the response is accepted.
module alu_cmd_sequencer #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  input  logic [3:0]  req_cmd,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_cmd,
  output logic        alu_en,
  input  logic [15:0] alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [7:0]  op_count
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RESP
  } state_t;

  localparam logic [3:0] CMD_MAX = 4'b0100;
  localparam logic [2:0] LAT     = 3'(ALU_LAT);

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic        req_ready_n;
  logic [7:0]  alu_a_n, alu_b_n;
  logic [3:0]  alu_cmd_n;
  logic        alu_en_n;
  logic        rsp_valid_n;
  logic [15:0] rsp_data_n;
  logic        rsp_err_n;
  logic [7:0]  op_count_n;
  logic        legal;

  assign legal = (req_cmd <= CMD_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cmd   <= '0;
      alu_en    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      op_count  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      req_ready <= req_ready_n;
      alu_a     <= alu_a_n;
      alu_b     <= alu_b_n;
      alu_cmd   <= alu_cmd_n;
      alu_en    <= alu_en_n;
      rsp_valid <= rsp_valid_n;
      rsp_data  <= rsp_data_n;
      rsp_err   <= rsp_err_n;
      op_count  <= op_count_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    alu_a_n     = alu_a;
    alu_b_n     = alu_b;
    alu_cmd_n   = alu_cmd;
    alu_en_n    = alu_en;
    rsp_valid_n = rsp_valid;
    rsp_data_n  = rsp_data;
    rsp_err_n   = rsp_err;
    op_count_n  = op_count;

    unique case (state)
      IDLE: begin
        unique case (1'b1)
          (req_valid && legal): begin
            alu_a_n   = req_a;
            alu_b_n   = req_b;
            alu_cmd_n = req_cmd;
            alu_en_n  = 1'b1;
            cnt_n     = LAT;
            state_n   = DRIVE;
          end
          (req_valid && !legal): begin
            // Illegal opcode: answer at once, ALU untouched
            rsp_data_n  = '0;
            rsp_err_n   = 1'b1;
            rsp_valid_n = 1'b1;
            state_n     = RESP;
          end
          default: ;
        endcase
      end
      DRIVE: begin
        cnt_n = cnt - 3'd1;
        if (cnt == 3'd1) begin
          alu_en_n    = 1'b0;
          rsp_data_n  = alu_out;
          rsp_err_n   = 1'b0;
          rsp_valid_n = 1'b1;
          state_n     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
          if (!rsp_err) begin
            op_count_n = op_count + 8'd1;
          end
        end
      end
      default: begin
        state_n  = IDLE;
        alu_en_n = 1'b0;
      end
    endcase

    req_ready_n = (state_n == IDLE);
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: one instance with ALU_LAT=1, one with ALU_LAT=3.
// Each instance gets a behavioural ALU; a select line routes shared stimulus.
module tb_alu_cmd_sequencer;

  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        rv;
  logic        rsp_ready;
  logic [7:0]  req_a, req_b;
  logic [3:0]  req_cmd;

  logic        rv1, rr1, ae1, vv1, re1;
  logic [7:0]  aa1, ab1, oc1;
  logic [3:0]  ac1;
  logic [15:0] ao1, rd1;
  logic        rv3, rr3, ae3, vv3, re3;
  logic [7:0]  aa3, ab3, oc3;
  logic [3:0]  ac3;
  logic [15:0] ao3, rd3;

  logic        req_ready, alu_en, rsp_valid, rsp_err;
  logic [7:0]  alu_a, alu_b, op_count;
  logic [3:0]  alu_cmd;
  logic [15:0] rsp_data;

  int n_cmp = 0;
  int n_bad = 0;
  int ec1 = 0;
  int ec3 = 0;

  logic [7:0] exp_cnt;
  logic [7:0] last_a, last_b;
  logic [3:0] last_cmd;

  always #5 clk = ~clk;

  assign rv1 = rv & ~sel;
  assign rv3 = rv & sel;

  assign req_ready = sel ? rr3 : rr1;
  assign alu_en    = sel ? ae3 : ae1;
  assign rsp_valid = sel ? vv3 : vv1;
  assign rsp_err   = sel ? re3 : re1;
  assign alu_a     = sel ? aa3 : aa1;
  assign alu_b     = sel ? ab3 : ab1;
  assign alu_cmd   = sel ? ac3 : ac1;
  assign op_count  = sel ? oc3 : oc1;
  assign rsp_data  = sel ? rd3 : rd1;

  alu_cmd_sequencer #(.ALU_LAT(LAT1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(rv1), .req_ready(rr1),
    .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd),
    .alu_a(aa1), .alu_b(ab1), .alu_cmd(ac1), .alu_en(ae1),
    .alu_out(ao1),
    .rsp_valid(vv1), .rsp_ready(rsp_ready),
    .rsp_data(rd1), .rsp_err(re1), .op_count(oc1)
  );

  alu_cmd_sequencer #(.ALU_LAT(LAT3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(rv3), .req_ready(rr3),
    .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd),
    .alu_a(aa3), .alu_b(ab3), .alu_cmd(ac3), .alu_en(ae3),
    .alu_out(ao3),
    .rsp_valid(vv3), .rsp_ready(rsp_ready),
    .rsp_data(rd3), .rsp_err(re3), .op_count(oc3)
  );

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] c);
    logic [15:0] r;
    r = '0;
    case (c)
      4'b0000: r = {8'h00, a} + {8'h00, b};
      4'b0001: r = {8'h00, a} - {8'h00, b};
      4'b0010: r = {8'h00, a & b};
      4'b0011: r = {8'h00, a | b};
      4'b0100: r = {8'h00, ~a};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Result appears only after the enable has been held for the full latency
  always @(posedge clk) ec1 <= ae1 ? ec1 + 1 : 0;
  always @(posedge clk) ec3 <= ae3 ? ec3 + 1 : 0;
  assign ao1 = (ae1 && ec1 == LAT1 - 1) ? alu_f(aa1, ab1, ac1) : 16'h0000;
  assign ao3 = (ae3 && ec3 == LAT3 - 1) ? alu_f(aa3, ab3, ac3) : 16'h0000;

  task automatic chk(input string nm, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0h, want %0h", nm, what, act, exp);
    end
  endtask

  task automatic issue(input string nm, input logic [3:0] c,
                       input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    chk(nm, "req_ready_idle", 32'(req_ready), 32'd1);
    req_cmd = c;
    req_a   = a;
    req_b   = b;
    rv      = 1'b1;
    @(posedge clk);
    #1;
    rv = 1'b0;
  endtask

  task automatic wait_rsp(output bit seen, output int cyc, output int en);
    seen = 1'b0;
    cyc  = 0;
    en   = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (alu_en) en++;
      if (rsp_valid) begin
        seen = 1'b1;
        cyc  = k;
      end
    end
  endtask

  task automatic run_vec(input string nm, input logic [3:0] c,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] ed, input logic ee, input int lat);
    bit seen;
    int cyc, en;
    issue(nm, c, a, b);
    wait_rsp(seen, cyc, en);
    chk(nm, "rsp_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk(nm, "rsp_data", 32'(rsp_data), 32'(ed));
      chk(nm, "rsp_err", 32'(rsp_err), 32'(ee));
      chk(nm, "latency", 32'(cyc), ee ? 32'd1 : 32'(lat + 1));
      chk(nm, "en_cycles", 32'(en), ee ? 32'd0 : 32'(lat));
      chk(nm, "req_ready_resp", 32'(req_ready), 32'd0);
      chk(nm, "alu_a_hold", 32'(alu_a), ee ? 32'(last_a) : 32'(a));
      chk(nm, "alu_b_hold", 32'(alu_b), ee ? 32'(last_b) : 32'(b));
      chk(nm, "alu_cmd_hold", 32'(alu_cmd), ee ? 32'(last_cmd) : 32'(c));
      if (!ee) begin
        last_a   = a;
        last_b   = b;
        last_cmd = c;
        exp_cnt  = exp_cnt + 8'd1;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk(nm, "rsp_valid_drop", 32'(rsp_valid), 32'd0);
      chk(nm, "req_ready_back", 32'(req_ready), 32'd1);
      chk(nm, "op_count", 32'(op_count), 32'(exp_cnt));
    end
  endtask

  typedef struct {
    string       name;
    logic [3:0]  cmd;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] data;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    bit seen;
    int cyc, en;

    vecs[0]  = '{"add_20_10",  4'b0000, 8'd20,  8'd10,  16'd30,    1'b0};
    vecs[1]  = '{"sub_20_30",  4'b0001, 8'd20,  8'd30,  16'hFFF6,  1'b0};
    vecs[2]  = '{"and_6_4",    4'b0010, 8'd6,   8'd4,   16'd4,     1'b0};
    vecs[3]  = '{"or_6_4",     4'b0011, 8'd6,   8'd4,   16'd6,     1'b0};
    vecs[4]  = '{"not_5",      4'b0100, 8'd5,   8'd0,   16'h00FA,  1'b0};
    vecs[5]  = '{"ill_7",      4'b0111, 8'd1,   8'd1,   16'h0000,  1'b1};
    vecs[6]  = '{"add_ff_ff",  4'b0000, 8'hFF,  8'hFF,  16'h01FE,  1'b0};
    vecs[7]  = '{"sub_0_1",    4'b0001, 8'h00,  8'h01,  16'hFFFF,  1'b0};
    vecs[8]  = '{"ill_f",      4'b1111, 8'hAA,  8'h55,  16'h0000,  1'b1};
    vecs[9]  = '{"and_ff_0f",  4'b0010, 8'hFF,  8'h0F,  16'h000F,  1'b0};
    vecs[10] = '{"not_0",      4'b0100, 8'h00,  8'h33,  16'h00FF,  1'b0};
    vecs[11] = '{"ill_5",      4'b0101, 8'h12,  8'h34,  16'h0000,  1'b1};

    sel       = 1'b0;
    rv        = 1'b0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_cmd   = '0;
    exp_cnt   = '0;
    last_a    = '0;
    last_b    = '0;
    last_cmd  = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", "req_ready", 32'(req_ready), 32'd1);
    chk("reset", "alu_en", 32'(alu_en), 32'd0);
    chk("reset", "rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset", "op_count", 32'(op_count), 32'd0);
    chk("reset", "alu_a", 32'(alu_a), 32'd0);
    chk("reset", "rsp_data", 32'(rsp_data), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i].name, vecs[i].cmd, vecs[i].a, vecs[i].b,
              vecs[i].data, vecs[i].err, LAT1);
    end

    // Stalled consumer with a second request waiting
    issue("stall", 4'b0000, 8'd3, 8'd4);
    wait_rsp(seen, cyc, en);
    chk("stall", "rsp_seen", 32'(seen), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) @(negedge clk);
      chk("stall", "rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall", "rsp_data", 32'(rsp_data), 32'd7);
      chk("stall", "req_ready", 32'(req_ready), 32'd0);
      chk("stall", "alu_en", 32'(alu_en), 32'd0);
      req_a   = 8'd9;
      req_b   = 8'd9;
      req_cmd = 4'b0000;
      rv      = 1'b1;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    chk("stall", "rsp_data_c6", 32'(rsp_data), 32'd7);
    chk("stall", "req_ready_c6", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    rv        = 1'b0;
    exp_cnt   = exp_cnt + 8'd1;
    @(negedge clk);
    chk("stall", "rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("stall", "req_ready_back", 32'(req_ready), 32'd1);
    chk("stall", "op_count", 32'(op_count), 32'(exp_cnt));
    @(negedge clk);
    chk("stall", "ignored_alu_a", 32'(alu_a), 32'd3);
    chk("stall", "ignored_alu_en", 32'(alu_en), 32'd0);

    // Reset in the middle of a three-cycle drive
    sel = 1'b1;
    issue("abort", 4'b0000, 8'd3, 8'd4);
    @(negedge clk);
    chk("abort", "alu_en_c1", 32'(alu_en), 32'd1);
    @(negedge clk);
    chk("abort", "alu_en_c2", 32'(alu_en), 32'd1);
    chk("abort", "rsp_valid_c2", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort", "alu_a", 32'(alu_a), 32'd0);
    chk("abort", "alu_b", 32'(alu_b), 32'd0);
    chk("abort", "alu_cmd", 32'(alu_cmd), 32'd0);
    chk("abort", "alu_en", 32'(alu_en), 32'd0);
    chk("abort", "rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort", "rsp_data", 32'(rsp_data), 32'd0);
    chk("abort", "rsp_err", 32'(rsp_err), 32'd0);
    chk("abort", "op_count", 32'(op_count), 32'd0);
    chk("abort", "req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort", "no_rsp", 32'(rsp_valid), 32'd0);
    end
    exp_cnt  = '0;
    last_a   = '0;
    last_b   = '0;
    last_cmd = '0;

    for (int i = 0; i < 256; i++) begin
      run_vec("wrap", 4'b0000, 8'(i), 8'd1, 16'(i + 1), 1'b0, LAT3);
      if (i == 254) chk("wrap", "op_count_255", 32'(op_count), 32'd255);
    end
    chk("wrap", "op_count_0", 32'(op_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
